// File: rtl/p_hit_point_pkg.sv
// Shared types and fixed-point helper for the hit-point stage.
package p_hit_pkg;

  localparam int unsigned Q_BITS_DEF = 10;

  typedef logic signed [2:0][31:0] vec3_t;

  typedef struct packed {
    vec3_t              p;
    logic signed [31:0] t;
    logic               hit;
  } hit_rec_t;

  // Full 64-bit product, arithmetic shift (floors toward -inf), then truncate.
  function automatic logic signed [31:0] fx_mul(input logic signed [31:0] a,
                                                input logic signed [31:0] b,
                                                input int unsigned        q);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    logic signed [63:0] m;
    ea = a;
    eb = b;
    m  = ea * eb;
    m  = m >>> q;
    return m[31:0];
  endfunction

endpackage

// File: rtl/p_hit_point_if.sv
// Ray, divider-FIFO and output-buffer signals of the hit-point stage.
interface p_hit_point_if;
  import p_hit_pkg::*;

  vec3_t              origin;
  vec3_t              dir;
  logic               ray_wr_en;
  logic               ray_full;
  logic signed [31:0] t_in;
  logic               t_empty;
  logic               t_rd_en;
  vec3_t              p_out;
  logic signed [31:0] t_out;
  logic               hit_out;
  logic               out_empty;
  logic               out_rd_en;

  modport master (
    output origin, dir, ray_wr_en, t_in, t_empty, out_rd_en,
    input  ray_full, t_rd_en, p_out, t_out, hit_out, out_empty
  );

  modport slave (
    input  origin, dir, ray_wr_en, t_in, t_empty, out_rd_en,
    output ray_full, t_rd_en, p_out, t_out, hit_out, out_empty
  );
endinterface

// File: rtl/fifo_array.sv
// First-word-fall-through FIFO of ARRAY_SIZE words per entry; writes while full are ignored.
module fifo_array #(
  parameter int unsigned ARRAY_SIZE = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  wr_en,
  input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] din,
  output logic                                  full,
  input  logic                                  rd_en,
  output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] dout,
  output logic                                  empty
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        do_wr;
  logic        do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign dout  = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + ONE;
      if (do_rd) rd_ptr_q <= rd_ptr_q + ONE;
    end
  end
endmodule

// File: rtl/p_hit_point_buf.sv
// Circular FWFT result buffer; head holds the last popped entry while empty.
module hit_point_buf
  import p_hit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  hit_rec_t                 wr_data,
  input  logic                     rd_en,
  output hit_rec_t                 rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  hit_rec_t      mem_q [DEPTH];
  hit_rec_t      last_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_rd;

  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_rd   = rd_en && !empty;
  assign rd_data = empty ? last_q : mem_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
      count_q <= count_q + CW'(wr_en) - CW'(do_rd);
    end
  end
endmodule

// File: rtl/p_hit_point.sv
// Hit point P = origin + t*dir: pairs divider t with queued rays, 2-cycle pipeline into an FWFT buffer.
module p_hit_point
  import p_hit_pkg::*;
#(
  parameter int unsigned Q_BITS    = Q_BITS_DEF,
  parameter int unsigned RAY_DEPTH = 1024,
  parameter int unsigned OUT_DEPTH = 4
) (
  input logic          clock,
  input logic          reset,
  p_hit_point_if.slave bus
);
  localparam int unsigned CW = $clog2(OUT_DEPTH) + 1;

  logic [5:0][31:0]   ray_din;
  logic [5:0][31:0]   ray_dout;
  logic               ray_empty;
  vec3_t              ray_org;
  vec3_t              ray_dir;
  logic               issue;
  logic [CW-1:0]      buf_count;
  logic [CW:0]        occupancy;

  logic               s1_valid_q;
  vec3_t              s1_org_q;
  vec3_t              s1_prod_q;
  vec3_t              s1_prod_d;
  logic signed [31:0] s1_t_q;

  hit_rec_t           wr_rec;
  hit_rec_t           head;
  logic               buf_empty;

  assign ray_din = {bus.dir, bus.origin};

  fifo_array #(
    .ARRAY_SIZE(6),
    .DATA_WIDTH(32),
    .FIFO_DEPTH(RAY_DEPTH)
  ) u_ray_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (bus.ray_wr_en),
    .din   (ray_din),
    .full  (bus.ray_full),
    .rd_en (issue),
    .dout  (ray_dout),
    .empty (ray_empty)
  );

  assign ray_org = ray_dout[2:0];
  assign ray_dir = ray_dout[5:3];

  // The S2 stage writes straight into the buffer, so only S1 holds a result outside it.
  assign occupancy   = {1'b0, buf_count} + {{CW{1'b0}}, s1_valid_q};
  assign issue       = !bus.t_empty && !ray_empty && (occupancy < (CW+1)'(OUT_DEPTH));
  assign bus.t_rd_en = issue;

  always_comb begin
    s1_prod_d = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      s1_prod_d[i] = fx_mul(bus.t_in, $signed(ray_dir[i]), Q_BITS);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_org_q   <= '0;
      s1_prod_q  <= '0;
      s1_t_q     <= '0;
    end else begin
      s1_valid_q <= issue;
      if (issue) begin
        s1_org_q  <= ray_org;
        s1_prod_q <= s1_prod_d;
        s1_t_q    <= bus.t_in;
      end
    end
  end

  always_comb begin
    wr_rec = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      wr_rec.p[i] = s1_org_q[i] + s1_prod_q[i];
    end
    wr_rec.t   = s1_t_q;
    wr_rec.hit = (s1_t_q > 32'sd0);
  end

  hit_point_buf #(
    .DEPTH(OUT_DEPTH)
  ) u_buf (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (s1_valid_q),
    .wr_data (wr_rec),
    .rd_en   (bus.out_rd_en),
    .rd_data (head),
    .empty   (buf_empty),
    .count   (buf_count)
  );

  assign bus.p_out     = head.p;
  assign bus.t_out     = head.t;
  assign bus.hit_out   = head.hit;
  assign bus.out_empty = buf_empty;
endmodule

// File: tb/tb_p_hit_point.sv
// Scoreboard bench for p_hit_point: bench-side divider FIFO, directed vectors, decoupled output monitor.
module tb_p_hit_point;
  import p_hit_pkg::*;

  localparam int unsigned Q = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   issued   = 0;
  logic pop_t    = 1'b0;

  logic signed [31:0] tq[$];
  hit_rec_t           sbq[$];
  hit_rec_t           mon_e;

  p_hit_point_if bus();

  p_hit_point #(
    .Q_BITS(Q),
    .RAY_DEPTH(1024),
    .OUT_DEPTH(4)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  function void refresh();
    bus.t_empty = (tq.size() == 0);
    bus.t_in    = (tq.size() == 0) ? 32'sd0 : tq[0];
  endfunction

  function automatic vec3_t v3(input int a, input int b, input int c);
    vec3_t r;
    r[0] = a;
    r[1] = b;
    r[2] = c;
    return r;
  endfunction

  function automatic hit_rec_t rec(input vec3_t p, input int t, input logic h);
    hit_rec_t r;
    r.p   = p;
    r.t   = t;
    r.hit = h;
    return r;
  endfunction

  function automatic hit_rec_t model(input vec3_t o, input vec3_t d, input int t);
    hit_rec_t r;
    longint   pr;
    longint   s;
    for (int i = 0; i < 3; i++) begin
      pr     = (longint'(t) * longint'($signed(d[i]))) >>> Q;
      s      = longint'($signed(o[i])) + pr;
      r.p[i] = s[31:0];
    end
    r.t   = t;
    r.hit = (t > 0);
    return r;
  endfunction

  // Divider FIFO model: pop decided at negedge, applied at posedge, visible 1 time unit later.
  always @(negedge clk) begin
    pop_t = rst_n && bus.t_rd_en;
    if (pop_t) issued++;
  end

  always @(posedge clk) begin
    if (pop_t && tq.size() > 0) void'(tq.pop_front());
    #1 refresh();
  end

  always @(negedge clk) begin
    if (rst_n && bus.out_rd_en && !bus.out_empty) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out actual_p=%h actual_t=%0d required=none", bus.p_out, bus.t_out);
      end else begin
        mon_e = sbq.pop_front();
        chk("p_out", bus.p_out, mon_e.p);
        chk("t_out", bus.t_out, mon_e.t);
        chk("hit_out", bus.hit_out, mon_e.hit);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_t(input int t);
    tq.push_back(t);
    refresh();
  endtask

  task automatic push_ray(input vec3_t o, input vec3_t d);
    bus.origin    = o;
    bus.dir       = d;
    bus.ray_wr_en = 1'b1;
    tick();
    bus.ray_wr_en = 1'b0;
  endtask

  task automatic drain(input string name);
    bus.out_rd_en = 1'b1;
    for (int i = 0; i < 80 && sbq.size() > 0; i++) tick();
    bus.out_rd_en = 1'b0;
    chk({name, "_left"}, sbq.size(), 0);
    chk({name, "_empty"}, bus.out_empty, 1'b1);
  endtask

  function automatic void gen(input int k, output vec3_t o, output vec3_t d, output int t);
    o = v3(k * 37 - 200, 1000 - k * 91, k * k);
    d = v3(k * 150 - 1100, 512 + k, -k * 333);
    t = (k % 5 == 0) ? 0 : (k * 613 - 4000);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int    issue_at;
    int    fall_at;
    int    base;
    vec3_t o;
    vec3_t d;
    int    t;

    bus.origin    = '0;
    bus.dir       = '0;
    bus.ray_wr_en = 1'b0;
    bus.out_rd_en = 1'b0;
    refresh();
    repeat (3) tick();
    chk("rst_out_empty", bus.out_empty, 1'b1);
    chk("rst_t_rd_en", bus.t_rd_en, 1'b0);
    chk("rst_p_out", bus.p_out, 96'd0);
    chk("rst_t_out", bus.t_out, 32'd0);
    chk("rst_hit_out", bus.hit_out, 1'b0);
    chk("rst_ray_full", bus.ray_full, 1'b0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic hit plus latency from t_rd_en to out_empty falling
    push_t(2048);
    sbq.push_back(rec(v3(2048, 0, 0), 2048, 1'b1));
    push_ray(v3(0, 0, 0), v3(1024, 0, 0));
    issue_at = -100;
    fall_at  = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.t_rd_en && issue_at < 0) issue_at = i;
      if (!bus.out_empty && fall_at < 0) fall_at = i;
    end
    chk("basic_latency", fall_at - issue_at, 2);
    tick();
    drain("basic");
    chk("hold_p_out", bus.p_out, v3(2048, 0, 0));
    chk("hold_t_out", bus.t_out, 32'd2048);

    // Offset with negative t
    push_t(-1024);
    sbq.push_back(rec(v3(1024, -1536, 4096), -1024, 1'b0));
    push_ray(v3(1024, -512, 3072), v3(0, 1024, -1024));
    repeat (4) tick();
    drain("negt");

    // Floor rounding of t = -1 LSB
    push_t(-1);
    sbq.push_back(rec(v3(-1, -1, 0), -1, 1'b0));
    push_ray(v3(0, 0, 0), v3(1024, 1, 0));
    repeat (4) tick();
    drain("round");

    // Backpressure: 8 rays, output stalled
    base = issued;
    for (int k = 0; k < 8; k++) begin
      o = v3(k * 1000, -k * 3, 5);
      d = v3(1024, -2048 + k * 300, k * 7 - 20);
      t = k * 700 - 2000;
      push_t(t);
      sbq.push_back(model(o, d, t));
      push_ray(o, d);
    end
    repeat (10) tick();
    chk("bp_issued", issued - base, 4);
    chk("bp_t_rd_en", bus.t_rd_en, 1'b0);
    chk("bp_t_left", tq.size(), 4);
    drain("bp");
    chk("bp_all_issued", issued - base, 8);

    // Starvation skew: rays first, then t first
    base = issued;
    bus.out_rd_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      gen(k, o, d, t);
      sbq.push_back(model(o, d, t));
    end
    for (int k = 0; k < 8; k++) begin
      gen(k, o, d, t);
      push_ray(o, d);
    end
    repeat (5) tick();
    chk("skew_rays_only", issued - base, 0);
    for (int k = 0; k < 8; k++) begin
      gen(k, o, d, t);
      push_t(t);
      repeat (1 + k % 3) tick();
    end
    for (int i = 0; i < 20 && issued - base < 8; i++) tick();
    chk("skew_first_half", issued - base, 8);
    base = issued;
    for (int k = 8; k < 16; k++) begin
      gen(k, o, d, t);
      push_t(t);
    end
    repeat (4) tick();
    chk("skew_ts_only", issued - base, 0);
    for (int k = 8; k < 16; k++) begin
      gen(k, o, d, t);
      bus.out_rd_en = k[0];
      push_ray(o, d);
      repeat (k % 2) tick();
    end
    drain("skew");

    // Reset with results buffered and in flight
    for (int k = 0; k < 5; k++) push_t(k * 1024 + 1024);
    for (int k = 0; k < 5; k++) push_ray(v3(k, 0, 0), v3(1024, 1024, 1024));
    chk("pre_rst_nonempty", bus.out_empty, 1'b0);
    rst_n = 1'b0;
    sbq.delete();
    tq.delete();
    refresh();
    #1;
    chk("midrst_out_empty", bus.out_empty, 1'b1);
    chk("midrst_t_rd_en", bus.t_rd_en, 1'b0);
    chk("midrst_ray_full", bus.ray_full, 1'b0);
    chk("midrst_t_out", bus.t_out, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    push_t(3072);
    sbq.push_back(rec(v3(1543, -3079, 6244), 3072, 1'b1));
    push_ray(v3(7, -7, 100), v3(512, -1024, 2048));
    repeat (4) tick();
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
